// File: rtl/sram_queue_if.sv
// ---------------------------------------------------------------------------
// sram_queue_if
//   Bundles the producer side, the consumer side and the status outputs of
//   sram_queue into one interface.
//
//   Handshake rule (both channels): a transfer happens on a rising clock edge
//   where valid and ready are both high. The sender keeps valid and data
//   stable until that transfer. The receiver may raise or lower ready freely,
//   and ready never waits for valid.
//
//   Signals
//     in_valid    producer -> queue  producer has data
//     in_ready    queue -> producer  queue accepts data this cycle
//     in_data     producer -> queue  write data, WIDTH bits
//     out_valid   queue -> consumer  out_data holds the head entry
//     out_ready   consumer -> queue  consumer takes the head this cycle
//     out_data    queue -> consumer  head entry, WIDTH bits
//     count       queue -> status    total entries held, CNT_W bits
//     almost_full queue -> status    count >= AF_LEVEL
//
//   Modports
//     master  the producer/consumer side (drives in_*, out_ready)
//     slave   the queue itself
// ---------------------------------------------------------------------------
interface sram_queue_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 17
);
   localparam int CNT_W = $clog2(DEPTH + 3);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] count;
   logic             almost_full;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  count,
      input  almost_full
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output count,
      output almost_full
   );
endinterface

// File: rtl/sram_queue.sv
// ---------------------------------------------------------------------------
// sram_queue
//   Single-clock FIFO built on a 1R1W SRAM with a registered (1-cycle) read.
//   A 2-entry skid stage sits behind the SRAM read port so that the queue
//   streams one entry per cycle even though read data arrives one cycle after
//   the read is issued. The total capacity is DEPTH (SRAM) + 2 (skid and
//   in-flight read).
//
//   Ports
//     clock    single clock for all logic and both SRAM ports
//     reset_n  synchronous, active-low reset (has priority over flush)
//     flush    synchronous clear of all queue state. SRAM contents are kept
//              but become unreachable.
//     q        sram_queue_if.slave: in_valid/in_ready/in_data,
//              out_valid/out_ready/out_data, count, almost_full
//
//   Parameters
//     WIDTH     data bits per entry
//     DEPTH     SRAM entries (>= 2, any value, not only powers of two)
//     AF_LEVEL  almost_full threshold on total occupancy
// ---------------------------------------------------------------------------
module sram_queue #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 17,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        flush,
   sram_queue_if.slave q
);

   // Derived widths; not meant to be overridden.
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 3);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  AF_CNT    = CNT_W'(AF_LEVEL);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;     // entries resident in SRAM
   logic [CNT_W-1:0]  count_q, count_d;         // SRAM + in-flight + skid
   logic              rd_inflight_q, rd_inflight_d;
   logic [1:0]        skid_occ_q, skid_occ_d;
   logic [WIDTH-1:0]  skid_data_q [2];
   logic [WIDTH-1:0]  skid_data_d [2];

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic              clear;
   logic              in_ready;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic              in_fire;
   logic              out_fire;
   logic              rd_issue;
   logic [WIDTH-1:0]  rd_data;
   logic [2:0]        occ_after;   // skid occupancy at the end of this cycle
   logic              pop_skid;    // head leaves from the skid registers
   logic              store_ret;   // read return lands in the skid registers
   logic [1:0]        ret_slot;

   assign clear = ~reset_n | flush;

   // Acceptance depends only on SRAM room. The skid stage is fed from the
   // SRAM and never directly from the input.
   assign in_ready = (mem_cnt_q < DEPTH_CNT) & ~clear;

   // A read return is presented to the consumer in the cycle it arrives
   // (bypass) when the skid stage is empty. This gives the two-cycle
   // empty-queue latency and keeps the stream at one entry per cycle.
   assign out_valid = ((skid_occ_q != 2'd0) | rd_inflight_q) & ~clear;
   assign out_data  = ((skid_occ_q == 2'd0) && rd_inflight_q) ? rd_data
                                                               : skid_data_q[0];

   assign in_fire  = q.in_valid & in_ready;
   assign out_fire = out_valid & q.out_ready;

   assign occ_after = {1'b0, skid_occ_q} + {2'b00, rd_inflight_q}
                    - {2'b00, out_fire};

   // Issue only when the data returning next cycle is guaranteed a skid slot.
   // mem_cnt_q > 0 at cycle start means rptr_q != wptr_q whenever a write
   // can also happen, so a read never targets the address being written.
   assign rd_issue = (mem_cnt_q != '0) & (occ_after < 3'd2) & ~clear;

   assign pop_skid  = out_fire & (skid_occ_q != 2'd0);
   // With an empty skid, a popped return was consumed through the bypass.
   assign store_ret = rd_inflight_q & ~(out_fire & (skid_occ_q == 2'd0));
   assign ret_slot  = skid_occ_q - {1'b0, pop_skid};

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      wptr_d = wptr_q;
      if (in_fire) begin
         wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_W'(1);
      end

      rptr_d = rptr_q;
      if (rd_issue) begin
         rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + ADDR_W'(1);
      end

      mem_cnt_d     = mem_cnt_q + CNT_W'(in_fire) - CNT_W'(rd_issue);
      count_d       = count_q + CNT_W'(in_fire) - CNT_W'(out_fire);
      rd_inflight_d = rd_issue;
   end

   always_comb begin
      skid_data_d[0] = skid_data_q[0];
      skid_data_d[1] = skid_data_q[1];
      skid_occ_d     = occ_after[1:0];

      if (pop_skid) begin
         skid_data_d[0] = skid_data_q[1];
      end

      // A return only arrives when the skid holds at most one entry, so the
      // target slot is always 0 or 1.
      if (store_ret) begin
         if (ret_slot == 2'd0) begin
            skid_data_d[0] = rd_data;
         end else begin
            skid_data_d[1] = rd_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset_n || flush) begin
         wptr_q         <= '0;
         rptr_q         <= '0;
         mem_cnt_q      <= '0;
         count_q        <= '0;
         rd_inflight_q  <= 1'b0;   // drops any read return due next cycle
         skid_occ_q     <= 2'd0;
         skid_data_q[0] <= '0;
         skid_data_q[1] <= '0;
      end else begin
         wptr_q         <= wptr_d;
         rptr_q         <= rptr_d;
         mem_cnt_q      <= mem_cnt_d;
         count_q        <= count_d;
         rd_inflight_q  <= rd_inflight_d;
         skid_occ_q     <= skid_occ_d;
         skid_data_q[0] <= skid_data_d[0];
         skid_data_q[1] <= skid_data_d[1];
      end
   end

   // ------------------------------------------------------------------------
   // SRAM: one read port (registered data), one write port, same clock.
   // Enables are asserted only on an actual issue or write.
   // ------------------------------------------------------------------------
`ifdef SYNTHESIS
   // Hard macro generated for this DEPTH x WIDTH geometry (17 x 64).
   sdq_17x64 u_sram (
      .R0_addr (rptr_q),
      .R0_en   (rd_issue),
      .R0_clk  (clock),
      .R0_data (rd_data),
      .W0_addr (wptr_q),
      .W0_en   (in_fire),
      .W0_clk  (clock),
      .W0_data (q.in_data)
   );
`else
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (in_fire) begin
         mem_q[wptr_q] <= q.in_data;
      end
      if (rd_issue) begin
         rd_data_q <= mem_q[rptr_q];
      end
   end

   assign rd_data = rd_data_q;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign q.in_ready    = in_ready;
   assign q.out_valid   = out_valid;
   assign q.out_data    = out_data;
   assign q.count       = count_q;
   assign q.almost_full = (count_q >= AF_CNT);

endmodule

// File: tb/tb_sram_queue.sv
// ---------------------------------------------------------------------------
// tb_sram_queue
//   Bench for sram_queue (WIDTH=64, DEPTH=17). The reference is a plain queue
//   of accepted entries. Its size is the expected occupancy, and its head is
//   the expected out_data. Directed sequences cover latency, full, streaming,
//   flush and reset. A randomized phase covers backpressure.
// ---------------------------------------------------------------------------
module tb_sram_queue;
   localparam int W        = 64;
   localparam int DEPTH    = 17;
   localparam int AF_LEVEL = DEPTH - 2;
   localparam int CAP      = DEPTH + 2;

   logic clock;
   logic reset_n;
   logic flush;

   sram_queue_if #(.WIDTH(W), .DEPTH(DEPTH)) q_if ();

   sram_queue #(.WIDTH(W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (flush),
      .q       (q_if)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   int         starve     = 0;
   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic       prev_clear = 1'b1;
   logic [W-1:0] prev_data = '0;

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- monitor + reference model ----------------
   always @(negedge clock) begin
      logic clear;
      int   size;
      logic in_fire;
      logic out_fire;
      clear = !reset_n || flush;
      size  = exp_q.size();

      chk("count", 64'(q_if.count), 64'(size));
      chk("almost_full", 64'(q_if.almost_full), 64'(size >= AF_LEVEL));

      if (clear) begin
         chk("clr_in_ready", 64'(q_if.in_ready), 64'(0));
         chk("clr_out_valid", 64'(q_if.out_valid), 64'(0));
      end else begin
         if (size < DEPTH) chk("in_ready_room", 64'(q_if.in_ready), 64'(1));
         if (size >= CAP)  chk("in_ready_full", 64'(q_if.in_ready), 64'(0));
         if (size == 0) chk("empty_valid", 64'(q_if.out_valid), 64'(0));
         else if (q_if.out_valid) chk("head_data", q_if.out_data, exp_q[0]);
         if (prev_valid && !prev_ready && !prev_clear) begin
            chk("hold_valid", 64'(q_if.out_valid), 64'(1));
            chk("hold_data", q_if.out_data, prev_data);
         end
         // A held entry must become visible within two cycles.
         if (size > 0 && !q_if.out_valid) starve++;
         else starve = 0;
         if (starve > 0) chk("fill_latency", 64'(starve > 1), 64'(0));
         if (dut.rd_issue && dut.in_fire)
            chk("raw_addr", 64'(dut.rptr_q == dut.wptr_q), 64'(0));
      end

      in_fire  = q_if.in_valid && q_if.in_ready;
      out_fire = q_if.out_valid && q_if.out_ready;
      if (clear) begin
         exp_q.delete();
         starve = 0;
      end else begin
         if (out_fire && size > 0) void'(exp_q.pop_front());
         if (in_fire) exp_q.push_back(q_if.in_data);
      end
      prev_valid = q_if.out_valid;
      prev_ready = q_if.out_ready;
      prev_clear = clear;
      prev_data  = q_if.out_data;
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge clock); #1;
      reset_n = 1'b0; flush = 1'b0;
      q_if.in_valid = 1'b0; q_if.out_ready = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic push(input logic [W-1:0] d);
      int budget;
      budget = 50;
      @(posedge clock); #1;
      q_if.in_valid = 1'b1;
      q_if.in_data  = d;
      @(negedge clock);
      while (!q_if.in_ready && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      chk("push_accept", 64'(q_if.in_ready), 64'(1));
      @(posedge clock); #1;
      q_if.in_valid = 1'b0;
   endtask

   // Consecutive pushes without idle cycles between them.
   task automatic push_burst(input int n, input logic [W-1:0] base);
      for (int i = 0; i < n; i++) begin
         q_if.in_valid = 1'b1;
         q_if.in_data  = base + 64'(i);
         @(negedge clock);
         chk("burst_ready", 64'(q_if.in_ready), 64'(1));
         @(posedge clock); #1;
      end
      q_if.in_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 200;
      q_if.in_valid  = 1'b0;
      q_if.out_ready = 1'b1;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clock); #1;
         budget--;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
      q_if.out_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0; flush = 1'b0;
      q_if.in_valid = 1'b0; q_if.in_data = '0; q_if.out_ready = 1'b0;
      @(negedge clock);
      chk("rst_count", 64'(q_if.count), 64'(0));
      chk("rst_out_valid", 64'(q_if.out_valid), 64'(0));
      do_reset();
      @(negedge clock);
      chk("rst_out_data", q_if.out_data, 64'(0));
      chk("rst_in_ready", 64'(q_if.in_ready), 64'(1));

      // Single entry: push at T, visible at T+2, count 1 -> 0 on pop.
      do_reset();
      @(posedge clock); #1;
      q_if.in_valid = 1'b1; q_if.in_data = 64'hDEAD_BEEF;
      @(negedge clock);
      chk("se_ready_t0", 64'(q_if.in_ready), 64'(1));
      chk("se_valid_t0", 64'(q_if.out_valid), 64'(0));
      @(posedge clock); #1;
      q_if.in_valid = 1'b0;
      @(negedge clock);
      chk("se_valid_t1", 64'(q_if.out_valid), 64'(0));
      chk("se_count_t1", 64'(q_if.count), 64'(1));
      @(posedge clock); #1;
      q_if.out_ready = 1'b1;
      @(negedge clock);
      chk("se_valid_t2", 64'(q_if.out_valid), 64'(1));
      chk("se_data_t2", q_if.out_data, 64'hDEAD_BEEF);
      @(posedge clock); #1;
      q_if.out_ready = 1'b0;
      @(negedge clock);
      chk("se_count_t3", 64'(q_if.count), 64'(0));
      chk("se_valid_t3", 64'(q_if.out_valid), 64'(0));

      // Fill to full, hold in_valid against a full queue, then pop in order.
      do_reset();
      for (int i = 0; i < CAP; i++) push(64'(i));
      q_if.in_valid = 1'b1; q_if.in_data = 64'h99;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("full_in_ready", 64'(q_if.in_ready), 64'(0));
         chk("full_count", 64'(q_if.count), 64'(CAP));
         chk("full_af", 64'(q_if.almost_full), 64'(1));
         @(posedge clock); #1;
      end
      q_if.in_valid = 1'b0;
      drain();

      // Streaming: one pop per cycle after the two-cycle fill, count stays 2.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         q_if.in_valid = 1'b1; q_if.in_data = 64'h1000 + 64'(i); q_if.out_ready = 1'b1;
         @(negedge clock);
         if (i >= 2) begin
            chk("stream_valid", 64'(q_if.out_valid), 64'(1));
            chk("stream_count", 64'(q_if.count), 64'(2));
         end else begin
            chk("stream_fill_valid", 64'(q_if.out_valid), 64'(0));
         end
      end
      @(posedge clock); #1;
      drain();

      // Flush with a read in flight.
      do_reset();
      @(posedge clock); #1;
      push_burst(10, 64'h200);
      repeat (3) @(posedge clock);
      #1 q_if.out_ready = 1'b1;
      @(posedge clock); #1;
      q_if.out_ready = 1'b0; flush = 1'b1;
      @(negedge clock);
      chk("fl_inflight", 64'(dut.rd_inflight_q), 64'(1));
      @(posedge clock); #1;
      flush = 1'b0;
      @(negedge clock);
      chk("fl_count", 64'(q_if.count), 64'(0));
      chk("fl_out_valid", 64'(q_if.out_valid), 64'(0));
      chk("fl_out_data", q_if.out_data, 64'(0));
      chk("fl_in_ready", 64'(q_if.in_ready), 64'(1));
      @(negedge clock);
      chk("fl_no_stale", 64'(q_if.out_valid), 64'(0));
      @(posedge clock); #1;
      q_if.in_valid = 1'b1; q_if.in_data = 64'hA5;
      @(posedge clock); #1;
      q_if.in_valid = 1'b0;
      @(negedge clock);
      chk("fl_a5_t1", 64'(q_if.out_valid), 64'(0));
      @(negedge clock);
      chk("fl_a5_valid", 64'(q_if.out_valid), 64'(1));
      chk("fl_a5_data", q_if.out_data, 64'hA5);
      @(posedge clock); #1;
      drain();

      // Reset while full.
      do_reset();
      for (int i = 0; i < CAP; i++) push(64'h300 + 64'(i));
      @(posedge clock); #1;
      reset_n = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(negedge clock);
      chk("mr_count", 64'(q_if.count), 64'(0));
      chk("mr_out_valid", 64'(q_if.out_valid), 64'(0));
      chk("mr_af", 64'(q_if.almost_full), 64'(0));
      chk("mr_out_data", q_if.out_data, 64'(0));
      chk("mr_in_ready", 64'(q_if.in_ready), 64'(1));

      // Randomized backpressure, two load regimes, rare flushes.
      for (int i = 0; i < 2000; i++) begin
         @(posedge clock); #1;
         if (!q_if.in_valid || q_if.in_ready || $urandom_range(0, 3) == 0) begin
            q_if.in_valid = ($urandom_range(0, 99) < ((i < 1000) ? 70 : 35));
            q_if.in_data  = {$urandom, $urandom};
         end
         q_if.out_ready = ($urandom_range(0, 99) < 30);
         flush = ($urandom_range(0, 299) == 0);
      end
      @(posedge clock); #1;
      flush = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sram_queue.md
Name: sram_queue

Overview:
- Parametrised single-clock FIFO built on a 1R1W SRAM macro with a 1-cycle registered read.
- Adds valid/ready handshakes, a 2-entry output skid stage for full throughput, occupancy count, almost-full flag and synchronous flush.
- Successor to the fixed 17x64 macro wrapper; used for load/store and issue queues.

Parameters:
- WIDTH, 64, data bits per entry.
- DEPTH, 17, SRAM entries; need not be a power of two, must be ≥ 2.
- AF_LEVEL, DEPTH-2, total-occupancy threshold for almost_full.
- ADDR_W, clog2(DEPTH), SRAM address width; derived, do not override.
- CNT_W, clog2(DEPTH+3), width of count; derived.

Ports:
- clock  in  1  single clock for all logic and both SRAM ports (R0_clk = W0_clk = clock).
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all contents; takes effect like reset but without clearing SRAM data.
- in_valid  in  1  producer has data.
- in_ready  out  1  queue accepts data this cycle.
- in_data  in  WIDTH  write data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes data this cycle.
- out_data  out  WIDTH  head entry.
- count  out  CNT_W  total entries held: SRAM + in-flight read + skid stage.
- almost_full  out  1  count ≥ AF_LEVEL.

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid/out_data stay stable until out_fire.
- Capacity and flow control:
  - Total capacity is DEPTH+2.
  - in_ready = (mem_cnt < DEPTH) & ~flush, where mem_cnt counts SRAM-resident entries.
- Write path: in_fire writes in_data at wptr via W0; wptr advances DEPTH-1 -> 0 (explicit compare, no power-of-two wrap).
- Read issue:
  - Issue R0 at rptr when mem_cnt > 0 and (skid_occ + rd_inflight - out_fire) < 2.
  - rd_inflight is a 1-bit register set on issue.
  - rptr wraps as wptr.
  - Data returns next cycle and is pushed into the 2-entry skid stage in order.
- Read/write hazard:
  - Never read an address in the cycle it is written.
  - Because a read requires mem_cnt > 0 at cycle start, the read address is never the current wptr. The bench asserts this.
- Latency:
  - Empty queue: in_fire at cycle T gives the read issued at T+1 and out_valid at T+2.
  - Sustained streaming with out_ready=1: one entry per cycle after the initial 2-cycle fill.
- Count: count_next = count + in_fire - out_fire. The simultaneous case leaves it unchanged. count ≤ DEPTH+2 always.
- mem_cnt: mem_cnt_next = mem_cnt + in_fire - rd_issue.
- Full: at count = DEPTH+2, in_ready = 0. An in_valid held high is stalled with no loss or overwrite.
- Empty: out_valid = 0; out_ready is ignored; out_data holds its last value (don't-care).
- Flush or reset (reset_n = 0):
  - Next cycle: wptr = rptr = 0, mem_cnt = 0, count = 0, skid_occ = 0, rd_inflight = 0.
  - out_valid = 0, in_ready = 0 during the flush cycle, almost_full = 0, out_data = 0.
  - An in-flight read return arriving in the cycle after flush is discarded.
  - Reset has priority over flush.
- Reset values: in_ready = 0 during reset and 1 in the first cycle after release; out_valid = 0, count = 0, almost_full = 0, out_data = 0.
- SRAM: instantiate one sdq macro named by DEPTH x WIDTH, or the behavioural model (reg array, registered read) under a simulation define. R0_en/W0_en are driven only on issue/fire.

Test Plan (WIDTH=64, DEPTH=17):
- Single entry: reset, push 0xDEAD_BEEF at T -> out_valid at T+2 with out_data = 0xDEAD_BEEF; count goes 1 -> 0 on pop.
- Fill to full: push 0..18 with out_ready = 0 -> in_ready drops after the 19th entry, count = 19, almost_full asserted from count = 15; pop all and see 0..18 in order.
- Streaming: in_valid = out_ready = 1 for 100 cycles with an incrementing pattern -> after 2-cycle fill, one pop per cycle, no gaps, count constant at 2, data in order through ≥5 pointer wraps at 16 -> 0.
- Backpressure: random out_ready at 30% and random in_valid -> scoreboard match, out_data stable while out_valid & ~out_ready, no read/write same-address assertion fires.
- Flush mid-stream: 10 entries queued with a read in flight, pulse flush -> next cycle count = 0 and out_valid = 0, no stale data emitted; then push 0xA5 and receive 0xA5 two cycles later.
- Reset mid-operation: reset_n low for 1 cycle while full -> all outputs at reset values next cycle, in_ready = 1 after release.
